decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered RV32I decode stage that turns fetched 32-bit instructions into the control word consumed by the ALU and the rest of execute.
- Produces the 4-bit ALU operation code, operand selects, sign-extended immediate, register addresses and memory/branch controls.
- Sits between fetch and execute; one valid/ready handshake on each side, with flush support for taken branches and jumps.

Parameters:
XLEN, 32, data/immediate width (only 32 supported)
RESET_PC, 32'h0000_0000, pc_out value after reset

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  fetch presents instruction
in_ready  output  1  stage can accept
in_instr  input  32  raw instruction
in_pc  input  32  instruction address
flush  input  1  kill held and incoming instruction
out_valid  output  1  decoded word valid
out_ready  input  1  execute accepts
alu_op  output  4  alu_op_e code
op1_sel  output  2  0=rs1, 1=pc, 2=zero
op2_sel  output  1  0=rs2, 1=imm
imm  output  32  sign-extended immediate
rs1_addr, rs2_addr, rd_addr  output  5 each  register indices
reg_write  output  1  write rd
mem_read, mem_write  output  1 each  load/store
mem_size  output  3  funct3 of load/store
branch  output  1  conditional branch; cond in br_cond
br_cond  output  3  funct3 of branch
jump  output  1  JAL/JALR
illegal  output  1  undecodable instruction
pc_out  output  32  pc of decoded instruction

Behaviour:
- Reset (async, rst_n=0): out_valid=0, all control outputs 0, alu_op=ADD, imm=0, pc_out=RESET_PC.
- Handshake: transfer when valid&&ready on the same edge. in_ready = !out_valid || out_ready (combinational). Latency 1 cycle; throughput 1 per cycle.
- When out_valid=1 and out_ready=0, all outputs hold stable.
- flush=1: out_valid cleared next edge; input accepted in that cycle is discarded. flush overrides a simultaneous in_valid.
- ALU codes (package alu_op_e): ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10.
- Per-opcode decode:
  - OP: funct7=0000000 or 0100000 (the latter only with ADD/SRL funct3) selects SUB/SRA; any other funct7 is illegal.
  - OP-IMM: SRAI uses funct7[5]. SLLI/SRLI/SRAI with other funct7 bits set are illegal.
  - LUI: PASS_B, imm = U.
  - AUIPC: ADD, op1=pc, imm = U.
  - JAL/JALR: ADD, op1=pc, op2=imm=4; jump=1; target immediate is handled by the branch unit (outside this block).
  - Loads/stores: ADD rs1+imm, mem_size=funct3. Load funct3 3/6/7 and store funct3 >=3 are illegal.
  - Branches: SUB, op2=rs2, imm=B. funct3 2/3 are illegal.
  - MISC-MEM (FENCE/FENCE.I): decoded as NOP (ADD, reg_write=0).
  - SYSTEM: illegal=1 (CSR/ECALL handled elsewhere).
- Immediates: I/S/B/U/J forms, bit 31 sign-extended to 32 bits.
- Forced values: rd_addr=0 forces reg_write=0. illegal=1 forces reg_write, mem_read, mem_write, branch and jump to 0; out_valid is still asserted so execute can trap.
- Reset mid-stall: output word lost; no replay.

Optional Feature:
DECODE_SKID_EN:
- Defined: adds a one-entry skid buffer. in_ready becomes a pure register (= !skid_valid), with no combinational path from out_ready. A word arriving while the output stalls goes to the skid and drains first when out_ready rises. Full throughput preserved. flush clears both entries.
- Undefined: single register; in_ready as above.

Decomposition:
- Package riscv_pkg holds alu_op_e, opcode constants (OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, MISC_MEM, SYSTEM), op1_sel/op2_sel enums and a packed decode_word_t struct.
- Sub-module decode_comb: pure combinational instr -> decode_word_t. The stage itself holds only registers, handshake and skid logic.

Test Plan:
- 0x00500093 (ADDI x1,x0,5) -> next cycle out_valid=1, alu_op=ADD, op2_sel=1, imm=5, rd=1, reg_write=1.
- 0x402081B3 (SUB x3,x1,x2) -> alu_op=SUB, op2_sel=0, rs1=1, rs2=2, rd=3; 0x123452B7 (LUI x5) -> PASS_B, imm=0x12345000.
- 0xFE000EE3 (BEQ x0,x0,-4) -> branch=1, br_cond=0, imm=0xFFFFFFFC, reg_write=0.
- 0x00000000 -> illegal=1, out_valid=1, reg_write/mem_* = 0; 0x00100073 (EBREAK) -> illegal=1.
- out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, exactly one instr lost-free; skid variant accepts one extra instr, then in_ready=0.
- flush with held word and in_valid=1 -> out_valid=0 next cycle, neither word emitted; rst_n low mid-stall -> out_valid=0 immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode types, opcode constants and the ALU code mapping.
package riscv_pkg;

  typedef enum logic [3:0] {
    ADD    = 4'd0,
    SUB    = 4'd1,
    SLL    = 4'd2,
    SLT    = 4'd3,
    SLTU   = 4'd4,
    XOR    = 4'd5,
    SRL    = 4'd6,
    SRA    = 4'd7,
    OR     = 4'd8,
    AND    = 4'd9,
    PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {OP1_RS1 = 2'd0, OP1_PC = 2'd1, OP1_ZERO = 2'd2} op1_sel_e;
  typedef enum logic {OP2_RS2 = 1'b0, OP2_IMM = 1'b1} op2_sel_e;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  typedef struct packed {
    alu_op_e     alu_op;
    op1_sel_e    op1_sel;
    op2_sel_e    op2_sel;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_size;
    logic        branch;
    logic [2:0]  br_cond;
    logic        jump;
    logic        illegal;
  } decode_word_t;

  // funct3 picks the ALU family; alt selects the SUB/SRA variant of ADD/SRL
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? SUB : ADD;
      3'd1:    return SLL;
      3'd2:    return SLT;
      3'd3:    return SLTU;
      3'd4:    return XOR;
      3'd5:    return alt ? SRA : SRL;
      3'd6:    return OR;
      default: return AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_comb.sv
// decode_comb: purely combinational RV32I instruction -> control word decoder.
module decode_comb
  import riscv_pkg::*;
(
  input  logic [31:0]  i_instr,
  output decode_word_t o_word
);

  logic [6:0]   w_opc;
  logic [2:0]   w_f3;
  logic [6:0]   w_f7;
  logic [31:0]  w_imm_i;
  logic [31:0]  w_imm_s;
  logic [31:0]  w_imm_b;
  logic [31:0]  w_imm_u;
  decode_word_t w_raw;

  assign w_opc   = i_instr[6:0];
  assign w_f3    = i_instr[14:12];
  assign w_f7    = i_instr[31:25];
  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'h000};

  // raw per-opcode decode before the forcing rules are applied
  always_comb begin
    w_raw          = '0;
    w_raw.rs1_addr = i_instr[19:15];
    w_raw.rs2_addr = i_instr[24:20];
    w_raw.rd_addr  = i_instr[11:7];
    case (w_opc)
      OP: begin
        w_raw.alu_op    = alu_from_f3(w_f3, w_f7[5]);
        w_raw.reg_write = 1'b1;
        w_raw.illegal   = !(w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5)));
      end
      OP_IMM: begin
        w_raw.alu_op    = alu_from_f3(w_f3, w_f3 == 3'd5 && w_f7[5]);
        w_raw.op2_sel   = OP2_IMM;
        w_raw.imm       = w_imm_i;
        w_raw.reg_write = 1'b1;
        w_raw.illegal   = (w_f3 == 3'd1 && w_f7 != 7'h00) ||
                          (w_f3 == 3'd5 && (w_f7 & 7'b1011111) != 7'h00);
      end
      LUI: begin
        w_raw.alu_op    = PASS_B;
        w_raw.op1_sel   = OP1_ZERO;
        w_raw.op2_sel   = OP2_IMM;
        w_raw.imm       = w_imm_u;
        w_raw.reg_write = 1'b1;
      end
      AUIPC: begin
        w_raw.op1_sel   = OP1_PC;
        w_raw.op2_sel   = OP2_IMM;
        w_raw.imm       = w_imm_u;
        w_raw.reg_write = 1'b1;
      end
      JAL, JALR: begin
        w_raw.op1_sel   = OP1_PC;
        w_raw.op2_sel   = OP2_IMM;
        w_raw.imm       = 32'd4;
        w_raw.jump      = 1'b1;
        w_raw.reg_write = 1'b1;
      end
      LOAD: begin
        w_raw.op2_sel   = OP2_IMM;
        w_raw.imm       = w_imm_i;
        w_raw.mem_read  = 1'b1;
        w_raw.mem_size  = w_f3;
        w_raw.reg_write = 1'b1;
        w_raw.illegal   = w_f3 == 3'd3 || w_f3 >= 3'd6;
      end
      STORE: begin
        w_raw.op2_sel   = OP2_IMM;
        w_raw.imm       = w_imm_s;
        w_raw.mem_write = 1'b1;
        w_raw.mem_size  = w_f3;
        w_raw.illegal   = w_f3 >= 3'd3;
      end
      BRANCH: begin
        w_raw.alu_op  = SUB;
        w_raw.imm     = w_imm_b;
        w_raw.branch  = 1'b1;
        w_raw.br_cond = w_f3;
        w_raw.illegal = w_f3[2:1] == 2'b01;
      end
      MISC_MEM: w_raw.illegal = 1'b0;
      SYSTEM:   w_raw.illegal = 1'b1;
      default:  w_raw.illegal = 1'b1;
    endcase
  end

  // x0 never gets written; illegal words keep no side effects so execute can trap cleanly
  always_comb begin
    o_word           = w_raw;
    o_word.reg_write = w_raw.reg_write && w_raw.rd_addr != 5'd0 && !w_raw.illegal;
    o_word.mem_read  = w_raw.mem_read && !w_raw.illegal;
    o_word.mem_write = w_raw.mem_write && !w_raw.illegal;
    o_word.branch    = w_raw.branch && !w_raw.illegal;
    o_word.jump      = w_raw.jump && !w_raw.illegal;
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage with valid/ready on both sides and flush.
// Optional DECODE_SKID_EN adds a one-entry skid buffer so in_ready is a pure register.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [1:0]      op1_sel,
  output logic            op2_sel,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic [2:0]      mem_size,
  output logic            branch,
  output logic [2:0]      br_cond,
  output logic            jump,
  output logic            illegal,
  output logic [XLEN-1:0] pc_out
);

  decode_word_t    w_dec;
  decode_word_t    r_word;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;

  decode_comb u_decode_comb (
    .i_instr (in_instr),
    .o_word  (w_dec)
  );

`ifdef DECODE_SKID_EN
  decode_word_t    r_skid;
  logic [XLEN-1:0] r_skid_pc;
  logic            r_skid_valid;

  assign in_ready = !r_skid_valid;

  // output register refills from the skid first; a word arriving during a stall parks in the skid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_word       <= '0;
      r_pc         <= RESET_PC;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
      r_skid_pc    <= RESET_PC;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_valid || out_ready) begin
      if (r_skid_valid) begin
        r_valid      <= 1'b1;
        r_word       <= r_skid;
        r_pc         <= r_skid_pc;
        r_skid_valid <= 1'b0;
      end else begin
        r_valid <= in_valid;
        if (in_valid) begin
          r_word <= w_dec;
          r_pc   <= in_pc;
        end
      end
    end else if (in_valid && !r_skid_valid) begin
      r_skid_valid <= 1'b1;
      r_skid       <= w_dec;
      r_skid_pc    <= in_pc;
    end
  end
`else
  assign in_ready = !r_valid || out_ready;

  // single output register: load on accept, hold while stalled, drop on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_word  <= '0;
      r_pc    <= RESET_PC;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (in_ready) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_word <= w_dec;
        r_pc   <= in_pc;
      end
    end
  end
`endif

  assign out_valid = r_valid;
  assign alu_op    = r_word.alu_op;
  assign op1_sel   = r_word.op1_sel;
  assign op2_sel   = r_word.op2_sel;
  assign imm       = r_word.imm;
  assign rs1_addr  = r_word.rs1_addr;
  assign rs2_addr  = r_word.rs2_addr;
  assign rd_addr   = r_word.rd_addr;
  assign reg_write = r_word.reg_write;
  assign mem_read  = r_word.mem_read;
  assign mem_write = r_word.mem_write;
  assign mem_size  = r_word.mem_size;
  assign branch    = r_word.branch;
  assign br_cond   = r_word.br_cond;
  assign jump      = r_word.jump;
  assign illegal   = r_word.illegal;
  assign pc_out    = r_pc;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: vector table, corner sequences and random traffic against a behavioural model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        in_ready, out_valid, op2_sel, reg_write, mem_read, mem_write, branch, jump, illegal;
  logic [3:0]  alu_op;
  logic [1:0]  op1_sel;
  logic [31:0] imm, pc_out;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [2:0]  mem_size, br_cond;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
    .op1_sel(op1_sel), .op2_sel(op2_sel), .imm(imm), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .branch(branch), .br_cond(br_cond), .jump(jump), .illegal(illegal),
    .pc_out(pc_out)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  alu;
    logic [1:0]  op1;
    logic        op2;
    logic [31:0] imm;
    logic        rw, mr, mw;
    logic [2:0]  ms;
    logic        br;
    logic [2:0]  bc;
    logic        jmp, ill;
  } exp_t;

  // ALU code per funct3 for the base (non-alternate) operation; alternate forms are base+1
  localparam logic [31:0] ALU_TAB = {4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd0};

  exp_t q[$];
  exp_t vec[15];

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] pc);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7, opc;
    logic [31:0] i_imm, s_imm, b_imm, u_imm;
    logic writes;
    f3 = x[14:12];
    f7 = x[31:25];
    opc = x[6:0];
    i_imm = 32'($signed(x) >>> 20);
    s_imm = (i_imm & ~32'h1f) | 32'(x[11:7]);
    b_imm = {{20{x[31]}}, x[7], x[30:25], x[11:8], 1'b0};
    u_imm = x & 32'hFFFF_F000;
    e = '{default: '0};
    e.instr = x;
    e.pc = pc;
    writes = 1'b0;
    if (opc == 7'h33) begin
      e.alu = ALU_TAB[f3*4 +: 4] + ((f7 == 7'h20) ? 4'd1 : 4'd0);
      e.ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
      writes = 1'b1;
    end else if (opc == 7'h13) begin
      e.alu = ALU_TAB[f3*4 +: 4] + ((f3 == 5 && f7 == 7'h20) ? 4'd1 : 4'd0);
      e.op2 = 1'b1;
      e.imm = i_imm;
      e.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
      writes = 1'b1;
    end else if (opc == 7'h37) begin
      e.alu = 4'd10; e.op1 = 2'd2; e.op2 = 1'b1; e.imm = u_imm; writes = 1'b1;
    end else if (opc == 7'h17) begin
      e.op1 = 2'd1; e.op2 = 1'b1; e.imm = u_imm; writes = 1'b1;
    end else if (opc == 7'h6f || opc == 7'h67) begin
      e.op1 = 2'd1; e.op2 = 1'b1; e.imm = 32'd4; e.jmp = 1'b1; writes = 1'b1;
    end else if (opc == 7'h03) begin
      e.op2 = 1'b1; e.imm = i_imm; e.mr = 1'b1; e.ms = f3; writes = 1'b1;
      e.ill = (f3 == 3 || f3 > 5);
    end else if (opc == 7'h23) begin
      e.op2 = 1'b1; e.imm = s_imm; e.mw = 1'b1; e.ms = f3; e.ill = (f3 > 2);
    end else if (opc == 7'h63) begin
      e.alu = 4'd1; e.imm = b_imm; e.br = 1'b1; e.bc = f3; e.ill = (f3 == 2 || f3 == 3);
    end else if (opc != 7'h0f) begin
      e.ill = 1'b1;
    end
    e.rw = writes && x[11:7] != 0 && !e.ill;
    if (e.ill) begin
      e.mr = 1'b0; e.mw = 1'b0; e.br = 1'b0; e.jmp = 1'b0;
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] x, input int alu, op1, op2, input logic [31:0] im,
                              input int rw, mr, mw, ms, br, bc, jmp, ill);
    exp_t e;
    e = '{default: '0};
    e.instr = x; e.alu = 4'(alu); e.op1 = 2'(op1); e.op2 = 1'(op2); e.imm = im;
    e.rw = 1'(rw); e.mr = 1'(mr); e.mw = 1'(mw); e.ms = 3'(ms);
    e.br = 1'(br); e.bc = 3'(bc); e.jmp = 1'(jmp); e.ill = 1'(ill);
    return e;
  endfunction

  function automatic logic model_ready(input int depth, input logic rdy);
`ifdef DECODE_SKID_EN
    return depth < 2;
`else
    return depth == 0 || rdy;
`endif
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] x;
    int k;
    x = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0: x[6:0] = 7'h33;   1: x[6:0] = 7'h13;   2: x[6:0] = 7'h37;  3: x[6:0] = 7'h17;
      4: x[6:0] = 7'h6f;   5: x[6:0] = 7'h67;   6: x[6:0] = 7'h63;  7: x[6:0] = 7'h03;
      8: x[6:0] = 7'h23;   9: x[6:0] = 7'h0f;  10: x[6:0] = 7'h73;  default: ;
    endcase
    k = $urandom_range(0, 3);
    if (k == 0) x[31:25] = 7'h00;
    else if (k == 1) x[31:25] = 7'h20;
    return x;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic chk_word(input string t, input exp_t e);
    chk({t, ".illegal"}, 32'(illegal), 32'(e.ill));
    chk({t, ".reg_write"}, 32'(reg_write), 32'(e.rw));
    chk({t, ".mem_read"}, 32'(mem_read), 32'(e.mr));
    chk({t, ".mem_write"}, 32'(mem_write), 32'(e.mw));
    chk({t, ".branch"}, 32'(branch), 32'(e.br));
    chk({t, ".jump"}, 32'(jump), 32'(e.jmp));
    chk({t, ".rs1"}, 32'(rs1_addr), 32'(e.instr[19:15]));
    chk({t, ".rs2"}, 32'(rs2_addr), 32'(e.instr[24:20]));
    chk({t, ".rd"}, 32'(rd_addr), 32'(e.instr[11:7]));
    chk({t, ".pc"}, pc_out, e.pc);
    if (!e.ill) begin
      chk({t, ".alu_op"}, 32'(alu_op), 32'(e.alu));
      chk({t, ".op1_sel"}, 32'(op1_sel), 32'(e.op1));
      chk({t, ".op2_sel"}, 32'(op2_sel), 32'(e.op2));
      chk({t, ".imm"}, imm, e.imm);
      chk({t, ".mem_size"}, 32'(mem_size), 32'(e.ms));
      chk({t, ".br_cond"}, 32'(br_cond), 32'(e.bc));
    end
  endtask

  // one clock: drive between edges, check ready, update the model at the edge, check the output word
  task automatic cycle(input logic v, input logic [31:0] x, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    logic mr;
    in_valid = v; in_instr = x; in_pc = pc; out_ready = rdy; flush = fl;
    #1;
    mr = model_ready(q.size(), rdy);
    chk("in_ready", 32'(in_ready), 32'(mr));
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (v && mr) q.push_back(model(x, pc));
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk_word("word", q[0]);
  endtask

  initial begin
    vec[0]  = mk(32'h00500093, 0, 0, 1, 32'd5,        1, 0, 0, 0, 0, 0, 0, 0);
    vec[1]  = mk(32'h402081B3, 1, 0, 0, 32'd0,        1, 0, 0, 0, 0, 0, 0, 0);
    vec[2]  = mk(32'h123452B7, 10, 2, 1, 32'h12345000, 1, 0, 0, 0, 0, 0, 0, 0);
    vec[3]  = mk(32'hFE000EE3, 1, 0, 0, 32'hFFFFFFFC, 0, 0, 0, 0, 1, 0, 0, 0);
    vec[4]  = mk(32'h00000000, 0, 0, 0, 32'd0,        0, 0, 0, 0, 0, 0, 0, 1);
    vec[5]  = mk(32'h00100073, 0, 0, 0, 32'd0,        0, 0, 0, 0, 0, 0, 0, 1);
    vec[6]  = mk(32'h0020A423, 0, 0, 1, 32'd8,        0, 0, 1, 2, 0, 0, 0, 0);
    vec[7]  = mk(32'hFFF0A183, 0, 0, 1, 32'hFFFFFFFF, 1, 1, 0, 2, 0, 0, 0, 0);
    vec[8]  = mk(32'h000000EF, 0, 1, 1, 32'd4,        1, 0, 0, 0, 0, 0, 1, 0);
    vec[9]  = mk(32'h00001117, 0, 1, 1, 32'h1000,     1, 0, 0, 0, 0, 0, 0, 0);
    vec[10] = mk(32'h4030D093, 7, 0, 1, 32'h403,      1, 0, 0, 0, 0, 0, 0, 0);
    vec[11] = mk(32'h022081B3, 0, 0, 0, 32'd0,        0, 0, 0, 0, 0, 0, 0, 1);
    vec[12] = mk(32'h0FF0000F, 0, 0, 0, 32'd0,        0, 0, 0, 0, 0, 0, 0, 0);
    vec[13] = mk(32'h00000013, 0, 0, 1, 32'd0,        0, 0, 0, 0, 0, 0, 0, 0);
    vec[14] = mk(32'h0000B183, 0, 0, 0, 32'd0,        0, 0, 0, 0, 0, 0, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.alu_op", 32'(alu_op), 0);
    chk("rst.imm", imm, 0);
    chk("rst.pc_out", pc_out, 0);
    chk("rst.reg_write", 32'(reg_write), 0);
    chk("rst.mem", 32'({mem_read, mem_write, branch, jump, illegal}), 0);
    chk("rst.sel", 32'({op1_sel, op2_sel}), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      vec[i].pc = 32'h100 + 32'(i * 4);
      cycle(1'b1, vec[i].instr, vec[i].pc, 1'b1, 1'b0);
      chk_word($sformatf("vec%0d", i), vec[i]);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++)
      cycle(1'b1, vec[i].instr, 32'h200 + 32'(i * 4), 1'b0, 1'b0);
    chk("stall.in_ready", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    cycle(1'b1, vec[0].instr, 32'h300, 1'b0, 1'b0);
    cycle(1'b1, vec[1].instr, 32'h304, 1'b0, 1'b1);
    chk("flush.out_valid", 32'(out_valid), 0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    cycle(1'b1, vec[2].instr, 32'h400, 1'b0, 1'b0);
    cycle(1'b1, vec[3].instr, 32'h404, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.out_valid", 32'(out_valid), 0);
    chk("rst_mid.pc_out", pc_out, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
